// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch port (read-only)
// and the data port (read/write); one access in flight, one-cycle ack per completed access.
module mem_port_arbiter #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;

    localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

    state_t            state, state_nx;
    logic              gnt_d, gnt_d_nx;       // 1: current access belongs to the data port
    logic              last_d, last_d_nx;     // 1: previous grant went to the data port
    logic              acc_we, acc_we_nx;
    logic [ADDR_W-1:0] acc_addr, acc_addr_nx;
    logic [DATA_W-1:0] acc_wdata, acc_wdata_nx;
    logic [2:0]        cnt, cnt_nx;
    logic              pick_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt_d     <= 1'b0;
            last_d    <= 1'b0;
            acc_we    <= 1'b0;
            acc_addr  <= '0;
            acc_wdata <= '0;
            cnt       <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state     <= state_nx;
            gnt_d     <= gnt_d_nx;
            last_d    <= last_d_nx;
            acc_we    <= acc_we_nx;
            acc_addr  <= acc_addr_nx;
            acc_wdata <= acc_wdata_nx;
            cnt       <= cnt_nx;
            if (state == CAPTURE) begin
                if (gnt_d)
                    d_rdata <= mem_rdata;
                else
                    i_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        gnt_d_nx     = gnt_d;
        last_d_nx    = last_d;
        acc_we_nx    = acc_we;
        acc_addr_nx  = acc_addr;
        acc_wdata_nx = acc_wdata;
        cnt_nx       = cnt;
        // On a tie the port that did not win last time gets the memory
        pick_d       = d_req && (!i_req || !last_d);
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    gnt_d_nx     = pick_d;
                    last_d_nx    = pick_d;
                    acc_we_nx    = pick_d && d_we;
                    acc_addr_nx  = pick_d ? d_addr : i_addr;
                    acc_wdata_nx = pick_d ? d_wdata : '0;
                    state_nx     = ISSUE;
                end
            end
            ISSUE: begin
                if (acc_we) begin
                    state_nx = RESP;
                end else if (MEM_LAT == 1) begin
                    state_nx = CAPTURE;
                end else begin
                    cnt_nx   = CNT_LOAD;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 3'd1) begin
                    cnt_nx   = '0;
                    state_nx = CAPTURE;
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            CAPTURE: state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign mem_addr  = (state == ISSUE || state == WAIT || state == CAPTURE) ? acc_addr : '0;
    assign mem_wdata = (state == ISSUE && acc_we) ? acc_wdata : '0;
    assign mem_re    = (state == ISSUE) && !acc_we;
    assign mem_we    = (state == ISSUE) && acc_we;
    assign i_ack     = (state == RESP) && !gnt_d;
    assign d_ack     = (state == RESP) && gnt_d;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (MEM_LAT 2, 1, 4) over one shared
// behavioural memory, a vector table of single accesses plus hand-written multi-cycle sequences.
module tb_mem_port_arbiter;

    logic       clk;
    logic       mem_init;
    logic       rst       [3];
    logic       i_req     [3];
    logic [4:0] i_addr    [3];
    logic       i_ack     [3];
    logic [7:0] i_rdata   [3];
    logic       d_req     [3];
    logic       d_we      [3];
    logic [4:0] d_addr    [3];
    logic [7:0] d_wdata   [3];
    logic       d_ack     [3];
    logic [7:0] d_rdata   [3];
    logic [4:0] mem_addr  [3];
    logic [7:0] mem_wdata [3];
    logic       mem_re    [3];
    logic       mem_we    [3];
    logic [7:0] mem_rdata [3];
    logic       busy      [3];
    logic [7:0] mem       [32];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int a);
        if (a == 3) return 8'hA5;
        if (a == 7) return 8'h11;
        return 8'h40 + 8'(a);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int a = 0; a < 32; a++) mem[a] <= init_val(a);
        end else begin
            for (int k = 0; k < 3; k++)
                if (mem_we[k]) mem[mem_addr[k]] <= mem_wdata[k];
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        logic [4:0] pa [LAT];
        logic       pv [LAT];
        always @(posedge clk) begin
            pa[0] <= mem_addr[g];
            pv[0] <= mem_init ? 1'b0 : mem_re[g];
            for (int j = 1; j < LAT; j++) begin
                pa[j] <= pa[j-1];
                pv[j] <= mem_init ? 1'b0 : pv[j-1];
            end
        end
        // Data only appears exactly LAT cycles after the read strobe
        assign mem_rdata[g] = pv[LAT-1] ? mem[pa[LAT-1]] : 8'hEE;

        mem_port_arbiter #(.ADDR_W(5), .DATA_W(8), .MEM_LAT(LAT)) u_dut (
            .clk(clk), .rst(rst[g]),
            .i_req(i_req[g]), .i_addr(i_addr[g]), .i_ack(i_ack[g]), .i_rdata(i_rdata[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_re(mem_re[g]),
            .mem_we(mem_we[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] out_pack(input int k);
        return 64'({i_ack[k], d_ack[k], mem_re[k], mem_we[k], busy[k],
                    mem_addr[k], mem_wdata[k], i_rdata[k], d_rdata[k]});
    endfunction

    task automatic do_access(input int k, input bit is_d, input bit we, input logic [4:0] a,
                             input logic [7:0] wd, output int ack_cyc, output int stb_cyc,
                             output int nre, output int nwe, output int nbusy, output int nother,
                             output logic [7:0] rd, output logic [4:0] stb_addr,
                             output logic [7:0] stb_wdata, output logic [4:0] ack_maddr);
        ack_cyc = -1; stb_cyc = -1; nre = 0; nwe = 0; nbusy = 0; nother = 0;
        rd = '0; stb_addr = '0; stb_wdata = '0; ack_maddr = '1;
        @(posedge clk); #1;
        if (is_d) begin
            d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd;
        end else begin
            i_req[k] = 1'b1; i_addr[k] = a;
        end
        for (int c = 0; c < 20 && ack_cyc < 0; c++) begin
            @(negedge clk);
            if (mem_re[k]) begin nre++; stb_cyc = c; stb_addr = mem_addr[k]; end
            if (mem_we[k]) begin
                nwe++; stb_cyc = c; stb_addr = mem_addr[k]; stb_wdata = mem_wdata[k];
            end
            if (busy[k]) nbusy++;
            if (is_d ? i_ack[k] : d_ack[k]) nother++;
            if (is_d ? d_ack[k] : i_ack[k]) begin
                ack_cyc   = c;
                rd        = is_d ? d_rdata[k] : i_rdata[k];
                ack_maddr = mem_addr[k];
                i_req[k]  = 1'b0;
                d_req[k]  = 1'b0;
            end
        end
        i_req[k] = 1'b0;
        d_req[k] = 1'b0;
    endtask

    typedef struct {
        int         k;
        bit         is_d;
        bit         we;
        logic [4:0] addr;
        logic [7:0] wdata;
        int         exp_ack;
        logic [7:0] exp_rd;
    } vec_t;

    initial begin
        vec_t       vecs [9];
        int         ack_cyc, stb_cyc, nre, nwe, nbusy, nother, nack, both, ia, da, re1, re2, nr;
        logic [7:0] rd, pre_i, pre_d, stb_wdata;
        logic [4:0] stb_addr, ack_maddr;

        vecs[0] = '{0, 1'b0, 1'b0, 5'd3,  8'h00, 4, 8'hA5};
        vecs[1] = '{0, 1'b1, 1'b1, 5'd10, 8'h3C, 2, 8'h00};
        vecs[2] = '{0, 1'b1, 1'b0, 5'd10, 8'h00, 4, 8'h3C};
        vecs[3] = '{1, 1'b1, 1'b0, 5'd7,  8'h00, 3, 8'h11};
        vecs[4] = '{1, 1'b0, 1'b0, 5'd3,  8'h00, 3, 8'hA5};
        vecs[5] = '{2, 1'b0, 1'b0, 5'd5,  8'h00, 6, 8'h45};
        vecs[6] = '{2, 1'b1, 1'b1, 5'd5,  8'h77, 2, 8'h00};
        vecs[7] = '{2, 1'b1, 1'b0, 5'd5,  8'h00, 6, 8'h77};
        vecs[8] = '{0, 1'b0, 1'b0, 5'd5,  8'h00, 4, 8'h77};

        mem_init = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; i_req[k] = 1'b0; i_addr[k] = '0; d_req[k] = 1'b0;
            d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) check($sformatf("reset_outputs_u%0d", k), out_pack(k), 64'd0);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        mem_init = 1'b0;

        // Both ports requesting continuously from reset: D, I, D, I
        @(posedge clk); #1;
        i_req[0] = 1'b1; i_addr[0] = 5'd3;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 5'd7;
        nack = 0; both = 0;
        for (int c = 0; c < 60 && nack < 4; c++) begin
            @(negedge clk);
            if (i_ack[0] && d_ack[0]) both++;
            if (i_ack[0] || d_ack[0]) begin
                check($sformatf("fair_port_%0d", nack), 64'(d_ack[0]), 64'(nack % 2 == 0));
                check($sformatf("fair_cycle_%0d", nack), 64'(c), 64'(4 + 5 * nack));
                if (d_ack[0]) check("fair_d_rdata", 64'(d_rdata[0]), 64'h11);
                else          check("fair_i_rdata", 64'(i_rdata[0]), 64'hA5);
                nack++;
                if (nack == 4) begin i_req[0] = 1'b0; d_req[0] = 1'b0; end
            end
        end
        i_req[0] = 1'b0; d_req[0] = 1'b0;
        check("fair_ack_count", 64'(nack), 64'd4);
        check("fair_dual_ack", 64'(both), 64'd0);

        for (int v = 0; v < 9; v++) begin
            pre_i = i_rdata[vecs[v].k];
            pre_d = d_rdata[vecs[v].k];
            do_access(vecs[v].k, vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                      ack_cyc, stb_cyc, nre, nwe, nbusy, nother, rd, stb_addr, stb_wdata, ack_maddr);
            check($sformatf("v%0d_ack_cycle", v), 64'(ack_cyc), 64'(vecs[v].exp_ack));
            check($sformatf("v%0d_strobe_cycle", v), 64'(stb_cyc), 64'd1);
            check($sformatf("v%0d_re_count", v), 64'(nre), 64'(!vecs[v].we));
            check($sformatf("v%0d_we_count", v), 64'(nwe), 64'(vecs[v].we));
            check($sformatf("v%0d_strobe_addr", v), 64'(stb_addr), 64'(vecs[v].addr));
            check($sformatf("v%0d_busy_cycles", v), 64'(nbusy), 64'(vecs[v].exp_ack));
            check($sformatf("v%0d_other_ack", v), 64'(nother), 64'd0);
            check($sformatf("v%0d_resp_addr", v), 64'(ack_maddr), 64'd0);
            if (vecs[v].we) begin
                check($sformatf("v%0d_wdata", v), 64'(stb_wdata), 64'(vecs[v].wdata));
                check($sformatf("v%0d_mem", v), 64'(mem[vecs[v].addr]), 64'(vecs[v].wdata));
                check($sformatf("v%0d_d_rdata_kept", v), 64'(d_rdata[vecs[v].k]), 64'(pre_d));
            end else begin
                check($sformatf("v%0d_rdata", v), 64'(rd), 64'(vecs[v].exp_rd));
            end
            if (vecs[v].is_d) check($sformatf("v%0d_i_rdata_kept", v), 64'(i_rdata[vecs[v].k]), 64'(pre_i));
            else              check($sformatf("v%0d_d_rdata_kept", v), 64'(d_rdata[vecs[v].k]), 64'(pre_d));
        end

        // Reset during WAIT of a fetch (MEM_LAT=4), request held through reset
        @(posedge clk); #1;
        i_req[2] = 1'b1; i_addr[2] = 5'd3;
        repeat (3) @(negedge clk);
        check("rst_wait_busy_before", 64'(busy[2]), 64'd1);
        rst[2] = 1'b1;
        #1;
        check("rst_wait_immediate", out_pack(2), 64'd0);
        @(negedge clk);
        check("rst_wait_held", out_pack(2), 64'd0);
        rst[2] = 1'b0;
        ia = -1; nack = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (i_ack[2]) begin
                nack++;
                if (ia < 0) ia = c;
                i_req[2] = 1'b0;
            end
        end
        i_req[2] = 1'b0;
        check("rst_restart_ack_cycle", 64'(ia), 64'd6);
        check("rst_restart_ack_count", 64'(nack), 64'd1);
        check("rst_restart_rdata", 64'(i_rdata[2]), 64'hA5);

        // Data read arriving while a fetch waits (MEM_LAT=4)
        @(posedge clk); #1;
        i_req[2] = 1'b1; i_addr[2] = 5'd3;
        ia = -1; da = -1; re1 = -1; re2 = -1; nr = 0;
        for (int c = 0; c < 30 && da < 0; c++) begin
            @(negedge clk);
            if (c == 2) begin d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 5'd7; end
            if (mem_re[2]) begin
                nr++;
                if (re1 < 0) re1 = c; else re2 = c;
            end
            if (i_ack[2]) begin ia = c; i_req[2] = 1'b0; end
            if (d_ack[2]) begin da = c; d_req[2] = 1'b0; end
        end
        i_req[2] = 1'b0; d_req[2] = 1'b0;
        check("pend_i_ack_cycle", 64'(ia), 64'd6);
        check("pend_d_ack_cycle", 64'(da), 64'd13);
        check("pend_re_first", 64'(re1), 64'd1);
        check("pend_re_second", 64'(re2), 64'd8);
        check("pend_re_count", 64'(nr), 64'd2);
        check("pend_i_rdata", 64'(i_rdata[2]), 64'hA5);
        check("pend_d_rdata", 64'(d_rdata[2]), 64'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data memory between the fetch path (read-only) and the data path (push-operand read, pop-to-memory write).
- Arbitrates round-robin, sequences each access through issue/wait/response, and returns read data with a one-cycle acknowledge pulse.
- Sits between the multicycle stack-machine controller/datapath and the memory.
- Replaces the ad-hoc IorD-steered memory access with a request/acknowledge handshake.

Parameters:
- ADDR_W, 5, address width of memory and both request ports
- DATA_W, 8, data width
- MEM_LAT, 2, read latency in cycles from the mem_re cycle to valid mem_rdata; legal range 1..7

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  fetch read request, level, held until i_ack
- i_addr  in  ADDR_W  fetch address, stable while i_req high
- i_ack  out  1  one-cycle pulse, fetch complete
- i_rdata  out  DATA_W  fetch read data, valid from i_ack cycle, held until next fetch completion
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1 = write, 0 = read; stable while d_req high
- d_addr  in  ADDR_W  data address, stable while d_req high
- d_wdata  in  DATA_W  write data, stable while d_req high
- d_ack  out  1  one-cycle pulse, data access complete
- d_rdata  out  DATA_W  data read data, valid from d_ack cycle of a read, held otherwise
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_re  out  1  memory read strobe, one cycle per read
- mem_we  out  1  memory write strobe, one cycle per write
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, immediate):
  - state = IDLE; last_grant = I; wait counter = 0.
  - All outputs are 0, including i_rdata and d_rdata.
  - Reset mid-access aborts the access: no ack is issued, and strobes drop in the same cycle.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, RESP.
  - IDLE: sample i_req and d_req.
    - Only one request high: grant it.
    - Both high: grant the port not equal to last_grant.
    - Latch grant, address, we and wdata into internal registers; go to ISSUE; update last_grant.
    - Neither high: stay in IDLE.
  - ISSUE, one cycle:
    - Drive mem_addr, and mem_wdata for writes, from the latched registers.
    - Assert mem_re for a read or mem_we for a write.
    - Write: go to RESP.
    - Read: if MEM_LAT = 1 go to CAPTURE; otherwise load the counter with MEM_LAT-1 and go to WAIT.
  - WAIT: mem_addr held; decrement the counter; when the counter reaches 1, go to CAPTURE. WAIT lasts MEM_LAT-1 cycles.
  - CAPTURE, one cycle: mem_rdata is valid; register it into i_rdata or d_rdata according to the grant; go to RESP.
  - RESP, one cycle: pulse i_ack or d_ack for the granted port; go to IDLE.
- Latency, with request first sampled in cycle 0:
  - Read: ack in cycle MEM_LAT+2.
  - Write: ack in cycle 2.
  - No pipelining: at most one access is in flight.
- Requester rules:
  - The requester deasserts req in the cycle after ack, unless it starts a new request.
  - A req still high in IDLE is treated as a new access.
  - Changing addr, we or wdata while req is high is illegal; the arbiter uses the values latched in IDLE.
- Fairness: with both ports requesting continuously, grants strictly alternate. The first tie after reset goes to D.
- A request arriving while busy waits; a pending request never bypasses the current one.
- mem_addr and mem_wdata are 0 in IDLE and RESP.
- The rdata of the non-granted port never changes.
- d_rdata is unchanged by a data write.
- i_req and d_req both going high in the same cycle as state returns to IDLE is handled by the normal IDLE rule.

Test Plan:
- Reset, then i_req=1, i_addr=5'd3, memory[3]=8'hA5, MEM_LAT=2 -> mem_re high in cycle 1 only, i_ack pulse in cycle 4, i_rdata=8'hA5; busy high cycles 1-4.
- d_req=1, d_we=1, d_addr=5'd10, d_wdata=8'h3C -> mem_we high in cycle 1 with mem_addr=10 and mem_wdata=8'h3C; d_ack in cycle 2; memory[10]=8'h3C; d_rdata unchanged.
- i_req and d_req both high continuously right after reset, 4 accesses -> grant order D, I, D, I; each ack pulses exactly once per access.
- MEM_LAT=1 build, data read of addr 7 (memory[7]=8'h11) -> no WAIT state, d_ack in cycle 3, d_rdata=8'h11.
- Assert rst during WAIT of a fetch -> outputs 0 immediately, no i_ack; after release with i_req held, the fetch restarts from IDLE and completes normally.
- MEM_LAT=4, d_req read arrives while a fetch is in WAIT -> the fetch completes first (i_ack), then the data read issues, with d_ack 6 cycles after the return to IDLE.
